// File: rtl/ahbl_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_slave_mem
// Purpose  : AHB-Lite responder backed by a word-addressed memory, with a
//            fixed number of wait states per OKAY beat and a 2-cycle ERROR
//            response for bad size, misalignment, out-of-range addresses and
//            a 4 KB always-error window.
// Revision : 1.0 - initial release
// ============================================================================
module ahbl_slave_mem #(
  parameter int          AWIDTH      = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERR_BASE    = 32'hFFFF_F000
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         DEPTH     = 1 << AWIDTH;
  // Counter preload; only meaningful when WAIT_STATES > 0.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                pend;        // OKAY data phase in progress
  logic                d_write;
  logic [1:0]          d_size;
  logic [AWIDTH+1:0]   d_addr;
  logic                ready_q;
  logic                resp_q;
  logic                accept;
  logic                addr_err;
  logic                commit;
  logic [3:0]          lane_en;
  logic [31:0]         mem [DEPTH];

  // Burst type, protection and lock carry no meaning for this responder.
  logic unused_ok;
  assign unused_ok = &{1'b0, HBURST, HPROT, HMASTLOCK};

  // Address-phase qualification and error classification of the incoming beat
  always_comb begin
    accept   = HSEL & HREADY & HTRANS[1];
    addr_err = 1'b0;
    if (HSIZE > 3'd2)                              addr_err = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])               addr_err = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))  addr_err = 1'b1;
    if (|HADDR[31:AWIDTH+2])                       addr_err = 1'b1;
    if (HADDR[31:12] == ERR_BASE[31:12])           addr_err = 1'b1;
  end

  // Response FSM: IDLE with pend set is the completion (DONE) cycle
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      pend     <= 1'b0;
      d_write  <= 1'b0;
      d_size   <= 2'd0;
      d_addr   <= '0;
      ready_q  <= 1'b1;
      resp_q   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          // Ready cycle (IDLE, DONE or ERR2): the current beat ends here and
          // a new address phase may be taken.
          state   <= ST_IDLE;
          pend    <= 1'b0;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          if (accept) begin
            d_addr  <= HADDR[AWIDTH+1:0];
            d_write <= HWRITE;
            d_size  <= HSIZE[1:0];
            if (addr_err) begin
              state   <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else begin
              pend <= 1'b1;
              if (WAIT_STATES > 0) begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_LOAD;
                ready_q  <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  // Write commits on the edge that closes the final OKAY cycle
  always_comb begin
    commit  = pend & d_write & (state == ST_IDLE);
    lane_en = 4'b0000;
    case (d_size)
      2'd0:    lane_en[d_addr[1:0]] = 1'b1;
      2'd1:    lane_en = d_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Storage: no reset, only the addressed little-endian lanes are updated
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[d_addr[AWIDTH+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Read data is the whole word for the full read data phase, zero otherwise
  always_comb begin
    HRDATA = 32'd0;
    if (pend && !d_write) HRDATA = mem[d_addr[AWIDTH+1:2]];
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_slave_mem
// Purpose  : Self-checking bench for ahbl_slave_mem. Three instances with
//            0, 3 and 5 wait states sit on one master; HREADY is muxed from
//            the selected instance. A per-cycle response queue predicts
//            HREADYOUT/HRESP/HRDATA from the transfer rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahbl_slave_mem;

  localparam int          AW       = 11;
  localparam int          NWORDS   = 32;           // words pre-filled and exercised
  localparam logic [31:0] ERR_BASE = 32'h0000_1000;
  localparam logic [31:0] MEM_END  = 32'h0000_2000; // 4 * 2^AW

  typedef struct {
    bit          rdy;
    bit          resp;
    bit          rd;
    bit          fin;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    bit          tchk;
    logic [31:0] texp;
  } ent_t;

  typedef struct {
    bit          sel;
    logic [1:0]  tr;
    logic [31:0] a;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    bit          blk;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        hsel_drv;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_blk;
  logic        bus_hready;
  logic [31:0] rdata_v [3];
  logic        ready_v [3];
  logic        resp_v  [3];
  int          cur;

  ent_t        q[$];
  logic [31:0] mm [3][NWORDS];
  int          n_checks;
  int          n_fail;
  logic [31:0] last_rd;

  always #5 HCLK = ~HCLK;

  assign bus_hready = hready_blk ? 1'b0 : ready_v[cur];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahbl_slave_mem #(
      .AWIDTH      (AW),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 5)),
      .ERR_BASE    (ERR_BASE)
    ) u_dut (
      .HCLK      (HCLK),
      .HRESETN   (HRESETN),
      .HSEL      (hsel_drv && (cur == g)),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (3'd0),
      .HPROT     (4'd3),
      .HMASTLOCK (1'b0),
      .HREADY    (bus_hready),
      .HWDATA    (hwdata),
      .HRDATA    (rdata_v[g]),
      .HREADYOUT (ready_v[g]),
      .HRESP     (resp_v[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  function automatic logic [31:0] fill_val(input int i);
    return 32'hA500_0000 ^ (i * 32'h0103_0507);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, cur, $time, got, exp);
    end
  endtask

  // Predict the cycle-by-cycle response of an accepted beat.
  task automatic push(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                      input logic [31:0] wd, input bit tchk, input logic [31:0] texp);
    ent_t e;
    bit   err;
    err = 0;
    if (sz > 3'd2) err = 1;
    else if ((a % (32'd1 << sz)) != 0) err = 1;
    if (a >= MEM_END) err = 1;
    if ((a >> 12) == (ERR_BASE >> 12)) err = 1;
    e = '{rdy:0, resp:0, rd:0, fin:0, wr:wr, addr:a, sz:sz, wd:wd, tchk:0, texp:0};
    if (err) begin
      e.resp = 1; q.push_back(e);
      e.rdy  = 1; q.push_back(e);
    end else begin
      e.rd = !wr;
      for (int i = 0; i < ws_of(cur); i++) q.push_back(e);
      e.rdy = 1; e.fin = 1; e.tchk = tchk; e.texp = texp;
      q.push_back(e);
    end
  endtask

  // Compare one data-phase cycle against the front of the queue.
  task automatic compare();
    ent_t        e;
    logic [31:0] er;
    int          idx;
    int          b;
    e = '{rdy:1, resp:0, rd:0, fin:0, wr:0, addr:0, sz:0, wd:0, tchk:0, texp:0};
    if (q.size() != 0) e = q.pop_front();
    idx = int'(e.addr >> 2) % NWORDS;
    b   = int'(e.addr % 4);
    er  = e.rd ? mm[cur][idx] : 32'd0;
    check("hreadyout", {31'd0, ready_v[cur]}, {31'd0, e.rdy});
    check("hresp",     {31'd0, resp_v[cur]},  {31'd0, e.resp});
    check("hrdata",    rdata_v[cur], er);
    if (e.tchk) check("table_rdata", rdata_v[cur], e.texp);
    if (e.fin && e.rd) last_rd = rdata_v[cur];
    if (e.fin && e.wr) begin
      case (e.sz)
        3'd0:    mm[cur][idx][8*b +: 8]           = hwdata[8*b +: 8];
        3'd1:    mm[cur][idx][16*(b/2) +: 16]     = hwdata[16*(b/2) +: 16];
        default: mm[cur][idx]                     = hwdata;
      endcase
    end
  endtask

  // One bus cycle: drive an address phase, clock it, then check the data phase.
  task automatic step(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                      input bit wr, input logic [2:0] sz, input logic [31:0] wd,
                      input bit blk, input bit tchk, input logic [31:0] texp,
                      output bit acc);
    hsel_drv   = sel;
    htrans     = tr;
    haddr      = a;
    hwrite     = wr;
    hsize      = sz;
    hready_blk = blk;
    #1;
    acc = sel && bus_hready && tr[1];
    @(posedge HCLK);
    if (acc) push(a, wr, sz, wd, tchk, texp);
    #1;
    hwdata = (q.size() != 0) ? q[0].wd : $urandom();
    @(negedge HCLK);
    compare();
  endtask

  // Present a beat until it is taken (or once, if it can never be taken).
  task automatic issue(input vec_t v);
    bit acc;
    int n;
    if (!(v.sel && v.tr[1]) || v.blk) begin
      step(v.sel, v.tr, v.a, v.wr, v.sz, v.wd, v.blk, 0, 0, acc);
    end else begin
      n = 0;
      acc = 0;
      while (!acc && n < 40) begin
        step(v.sel, v.tr, v.a, v.wr, v.sz, v.wd, 0, v.chk, v.exp, acc);
        n++;
      end
      if (!acc) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout dut%0d addr %h: got no accept expected accept", cur, v.a);
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      step(0, 2'd0, 32'd0, 0, 3'd0, 32'd0, 0, 0, 0, acc);
      n++;
    end
    step(0, 2'd0, 32'd0, 0, 3'd0, 32'd0, 0, 0, 0, acc);
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", cur, q.size());
      q.delete();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    vec_t v;
    bit   acc;
    int   kk;

    n_checks = 0; n_fail = 0; cur = 0; last_rd = 0;
    hsel_drv = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0;
    hwdata = 0; hready_blk = 0;
    foreach (mm[d, i]) mm[d][i] = 32'd0;

    // Reset values on every instance
    HRESETN = 1'b0;
    repeat (2) @(negedge HCLK);
    for (int d = 0; d < 3; d++) begin
      cur = d;
      check("reset_hreadyout", {31'd0, ready_v[d]}, 32'd1);
      check("reset_hresp",     {31'd0, resp_v[d]},  32'd0);
      check("reset_hrdata",    rdata_v[d],          32'd0);
    end
    HRESETN = 1'b1;

    // Known contents in the exercised words of every instance
    for (int d = 0; d < 3; d++) begin
      cur = d;
      for (int i = 0; i < NWORDS; i++) begin
        v = '{1, 2'd2, 32'(i * 4), 1, 3'd2, fill_val(i), 0, 0, 0};
        issue(v);
      end
      drain();
    end

    // Zero-wait directed table, applied back-to-back
    cur = 0;
    tab.push_back('{1, 2'd2, 32'h10,        1, 3'd2, 32'hDEADBEEF, 0, 0, 0});
    tab.push_back('{1, 2'd2, 32'h10,        0, 3'd2, 32'h0,        0, 1, 32'hDEADBEEF});
    tab.push_back('{1, 2'd2, 32'h20,        1, 3'd2, 32'h11223344, 0, 0, 0});
    tab.push_back('{1, 2'd3, 32'h21,        1, 3'd0, 32'hAAAAAAAA, 0, 0, 0});
    tab.push_back('{1, 2'd3, 32'h22,        1, 3'd1, 32'hBBCCBBCC, 0, 0, 0});
    tab.push_back('{1, 2'd2, 32'h20,        0, 3'd2, 32'h0,        0, 1, 32'hBBCCAA44});
    tab.push_back('{1, 2'd2, 32'h02,        1, 3'd2, 32'h55555555, 0, 0, 0});
    tab.push_back('{1, 2'd2, 32'h00,        0, 3'd2, 32'h0,        0, 1, fill_val(0)});
    tab.push_back('{1, 2'd2, ERR_BASE + 4,  1, 3'd2, 32'h66666666, 0, 0, 0});
    tab.push_back('{1, 2'd2, MEM_END,       0, 3'd2, 32'h0,        0, 0, 0});
    tab.push_back('{1, 2'd2, 32'h30,        1, 3'd3, 32'h77777777, 0, 0, 0});
    tab.push_back('{1, 2'd1, 32'h10,        1, 3'd2, 32'h0,        0, 0, 0});
    tab.push_back('{0, 2'd2, 32'h10,        1, 3'd2, 32'h0,        0, 0, 0});
    tab.push_back('{1, 2'd2, 32'h10,        1, 3'd2, 32'h0,        1, 0, 0});
    tab.push_back('{1, 2'd2, 32'h10,        0, 3'd2, 32'h0,        0, 1, 32'hDEADBEEF});
    tab.push_back('{1, 2'd2, 32'h30,        0, 3'd2, 32'h0,        0, 1, fill_val(12)});
    tab.push_back('{1, 2'd2, 32'h12,        0, 3'd1, 32'h0,        0, 1, 32'hDEADBEEF});
    foreach (tab[i]) issue(tab[i]);
    drain();

    // Three wait states: next NONSEQ is only taken on the ready cycle
    cur = 1;
    step(1, 2'd2, 32'h08, 0, 3'd2, 32'd0, 0, 0, 0, acc);
    check("ws_first_accept", {31'd0, acc}, 32'd1);
    kk = 0;
    acc = 0;
    for (int k = 1; k <= 10 && !acc; k++) begin
      step(1, 2'd2, 32'h0C, 1, 3'd2, 32'h600DF00D, 0, 0, 0, acc);
      kk = k;
    end
    check("ws_accept_cycle", 32'(kk), 32'd4);
    // HSEL dropped while our read is still in its data phase
    v = '{1, 2'd2, 32'h0C, 0, 3'd2, 32'h0, 0, 0, 0};
    issue(v);
    drain();
    check("hsel_drop_rdata", last_rd, 32'h600DF00D);

    // Reset two cycles into a five-wait-state write
    cur = 2;
    step(1, 2'd2, 32'h14, 1, 3'd2, 32'hCAFEF00D, 0, 0, 0, acc);
    check("rst_write_accept", {31'd0, acc}, 32'd1);
    step(0, 2'd0, 32'd0, 0, 3'd0, 32'd0, 0, 0, 0, acc);
    step(0, 2'd0, 32'd0, 0, 3'd0, 32'd0, 0, 0, 0, acc);
    #2;
    HRESETN = 1'b0;
    #1;
    check("rst_mid_hreadyout", {31'd0, ready_v[2]}, 32'd1);
    check("rst_mid_hresp",     {31'd0, resp_v[2]},  32'd0);
    check("rst_mid_hrdata",    rdata_v[2],          32'd0);
    q.delete();
    @(negedge HCLK);
    HRESETN = 1'b1;
    v = '{1, 2'd2, 32'h14, 0, 3'd2, 32'h0, 0, 0, 0};
    issue(v);
    drain();
    check("rst_old_value", last_rd, fill_val(5));

    // Randomised traffic on every instance
    for (int d = 0; d < 3; d++) begin
      cur = d;
      for (int n = 0; n < 250; n++) begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        r  = $urandom_range(0, 9);
        if (r == 0)      a = ERR_BASE + $urandom_range(0, 4095);
        else if (r == 1) a = MEM_END + $urandom_range(0, 1000);
        else             a = $urandom_range(0, NWORDS * 4 - 1);
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
        step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), a,
             1'($urandom_range(0, 1)), sz, $urandom(), 0, 0, 0, acc);
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
